short_poly_seq: RTL and testbench
=================================

SHORT_POLY_SEQ -- requirements
Module: short_poly_seq

Interface
REQ-001 Parameter P, default 757: number of coefficients emitted per run.
REQ-002 Parameter SEED_DEFAULT, default 32'h2545F491: seed substituted when the supplied seed is zero.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 seed  input  32  run seed; sampled when start is accepted.
REQ-007 abort  input  1  terminates the current run; sampled in RUN.
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 done  output  1  one-cycle pulse in DONE.
REQ-010 coef  output  13  two's-complement ternary coefficient: 13'h0000, 13'h0001 or 13'h1FFF.
REQ-011 coef_valid  output  1  coef and coef_idx are valid.
REQ-012 coef_ready  input  1  consumer accepts; a transfer occurs when coef_valid and coef_ready are both high at a rising edge.
REQ-013 coef_idx  output  10  index of the presented coefficient, 0..P-1.
REQ-014 weight  output  10  count of nonzero coefficients transferred in the current or last run.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE with start=1: state register s <= (seed==0 ? SEED_DEFAULT : seed); coef_idx <= 0; weight <= 0; next state RUN.
REQ-017 Step function: t1 = s^(s>>7); t2 = t1^(t1<<9); s_next = t2^(t2>>13); all 32-bit logical shifts, upper bits discarded.
REQ-018 In RUN, advance condition: coef_valid==0, or a transfer occurs on that edge and the transfer is not the last one.
REQ-019 On an advance, s <= s_next, and low bits s_next[1:0] are mapped as follows:
- 00 -> coef 13'h0000, coef_valid=1
- 01 -> coef 13'h0001, coef_valid=1
- 10 -> coef 13'h1FFF, coef_valid=1
- 11 -> rejected; coef_valid=0 for that cycle and the step retries on the next edge.
REQ-020 While coef_valid=1 and coef_ready=0, coef, coef_idx and s SHALL hold stable.
REQ-021 On each transfer, coef_idx increments by 1, except on the transfer of index P-1.
REQ-022 On each transfer of a nonzero coef, weight increments by 1, saturating at 10'h3FF.
REQ-023 On the transfer of index P-1: coef_valid <= 0 and next state DONE; s does not step.
REQ-024 DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-025 In IDLE, coef_idx and weight hold their final values.
REQ-026 abort=1 in RUN: coef_valid <= 0 and next state DONE, even if a transfer occurs on the same edge. That transfer still counts in weight and coef_idx.
REQ-027 start in RUN or DONE SHALL be ignored; no queuing.
REQ-028 Latency: the start edge loads s; the next edge performs the first step, so coef_valid is visible at the earliest 2 cycles after start is sampled.
REQ-029 With coef_ready held at 1 and no rejections, throughput SHALL be 1 coefficient per cycle.
REQ-030 coef_valid SHALL never be high outside RUN.

Reset
REQ-031 rst=1 at an edge SHALL force: IDLE, s=SEED_DEFAULT, coef=0, coef_valid=0, coef_idx=0, weight=0, busy=0, done=0.
REQ-032 rst SHALL take priority over start, abort and any transfer on the same edge.
REQ-033 rst asserted mid-run SHALL discard the run with no done pulse.

Verification
REQ-034 seed=32'h1, start pulse, coef_ready=1 -> first coef=13'h0001 with idx 0 (s=32'h00000201); second coef=13'h0001 with idx 1 (s=32'h00040825).
REQ-035 seed=0, start -> sequence identical to a run with seed=32'h2545F491.
REQ-036 P=757, coef_ready randomly toggled -> exactly 757 transfers with idx 0..756 in order, coef stable while stalled, weight equals the nonzero count, one done pulse, busy low afterwards.
REQ-037 abort asserted at idx 100 while coef_ready=1 -> that transfer is counted, coef_valid=0 next cycle, done pulses once, coef_idx=100.
REQ-038 rst asserted at idx 50 -> all outputs at reset values next cycle, no done pulse; a subsequent start with the same seed reproduces the identical sequence.
REQ-039 start held high through the whole run -> exactly one run per IDLE entry; a new run begins on the cycle after DONE.

Source files
------------

// File: rtl/short_poly_seq.sv
// Ternary coefficient generator: a seeded xorshift stream is mapped to {0,+1,-1}
// and emitted over a valid/ready handshake, P coefficients per run.
module short_poly_seq #(
    parameter int unsigned P            = 757,
    parameter logic [31:0] SEED_DEFAULT = 32'h2545F491
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] seed,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [12:0] coef,
    output logic        coef_valid,
    input  logic        coef_ready,
    output logic [9:0]  coef_idx,
    output logic [9:0]  weight
);

    localparam int unsigned SEED_W = 32;
    localparam int unsigned COEF_W = 13;
    localparam int unsigned IDX_W  = 10;
    localparam int unsigned WGT_W  = 10;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(P - 1);
    localparam logic [COEF_W-1:0] COEF_ZERO = '0;
    localparam logic [COEF_W-1:0] COEF_POS  = COEF_W'(1);
    localparam logic [COEF_W-1:0] COEF_NEG  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEED_W-1:0]   r_s;
    logic [SEED_W-1:0]   w_s_nxt;
    logic [SEED_W-1:0]   w_s_step;
    logic [COEF_W-1:0]   r_coef;
    logic [COEF_W-1:0]   w_coef_nxt;
    logic                r_coef_valid;
    logic                w_coef_valid_nxt;
    logic [IDX_W-1:0]    r_coef_idx;
    logic [IDX_W-1:0]    w_coef_idx_nxt;
    logic [WGT_W-1:0]    r_weight;
    logic [WGT_W-1:0]    w_weight_nxt;
    logic                r_busy;
    logic                r_done;
    logic                w_xfer;
    logic                w_last;

    // xorshift step: s ^= s>>7; s ^= s<<9; s ^= s>>13
    function automatic logic [SEED_W-1:0] xs_step(input logic [SEED_W-1:0] s);
        logic [SEED_W-1:0] t1;
        logic [SEED_W-1:0] t2;
        t1 = s ^ (s >> 7);
        t2 = t1 ^ (t1 << 9);
        return t2 ^ (t2 >> 13);
    endfunction

    assign w_s_step = xs_step(r_s);
    assign w_xfer   = r_coef_valid & coef_ready;
    assign w_last   = w_xfer && (r_coef_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        w_state_nxt      = r_state;
        w_s_nxt          = r_s;
        w_coef_nxt       = r_coef;
        w_coef_valid_nxt = r_coef_valid;
        w_coef_idx_nxt   = r_coef_idx;
        w_weight_nxt     = r_weight;

        case (r_state)
            S_IDLE: begin
                w_coef_valid_nxt = 1'b0;
                if (start) begin
                    w_s_nxt        = (seed == '0) ? SEED_DEFAULT : seed;
                    w_coef_idx_nxt = '0;
                    w_weight_nxt   = '0;
                    w_state_nxt    = S_RUN;
                end
            end
            S_RUN: begin
                if (w_xfer) begin
                    if (!w_last) begin
                        w_coef_idx_nxt = r_coef_idx + IDX_W'(1);
                    end
                    if ((r_coef != COEF_ZERO) && (r_weight != '1)) begin
                        w_weight_nxt = r_weight + WGT_W'(1);
                    end
                end
                // Abort and the final transfer both end the run without stepping s
                if (abort || w_last) begin
                    w_coef_valid_nxt = 1'b0;
                    w_state_nxt      = S_DONE;
                end else if (!r_coef_valid || w_xfer) begin
                    w_s_nxt = w_s_step;
                    case (w_s_step[1:0])
                        2'b00: begin
                            w_coef_nxt       = COEF_ZERO;
                            w_coef_valid_nxt = 1'b1;
                        end
                        2'b01: begin
                            w_coef_nxt       = COEF_POS;
                            w_coef_valid_nxt = 1'b1;
                        end
                        2'b10: begin
                            w_coef_nxt       = COEF_NEG;
                            w_coef_valid_nxt = 1'b1;
                        end
                        default: begin
                            w_coef_nxt       = COEF_ZERO;
                            w_coef_valid_nxt = 1'b0;
                        end
                    endcase
                end
            end
            S_DONE: begin
                w_coef_valid_nxt = 1'b0;
                w_state_nxt      = S_IDLE;
            end
            default: begin
                w_coef_valid_nxt = 1'b0;
                w_state_nxt      = S_IDLE;
            end
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s          <= SEED_DEFAULT;
            r_coef       <= COEF_ZERO;
            r_coef_valid <= 1'b0;
            r_coef_idx   <= '0;
            r_weight     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_s          <= w_s_nxt;
            r_coef       <= w_coef_nxt;
            r_coef_valid <= w_coef_valid_nxt;
            r_coef_idx   <= w_coef_idx_nxt;
            r_weight     <= w_weight_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign coef       = r_coef;
    assign coef_valid = r_coef_valid;
    assign coef_idx   = r_coef_idx;
    assign weight     = r_weight;

endmodule

// File: tb/tb_short_poly_seq.sv
// Directed bench for short_poly_seq: hand-computed first steps, full runs with
// stalls, abort, mid-run reset and start held high, against a small xorshift model.
module tb_short_poly_seq;

    localparam int unsigned P        = 757;
    localparam logic [31:0] SEED_DEF = 32'h2545F491;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] seed;
    logic        abort;
    logic        busy;
    logic        done;
    logic [12:0] coef;
    logic        coef_valid;
    logic        coef_ready;
    logic [9:0]  coef_idx;
    logic [9:0]  weight;

    int n_total = 0;
    int n_bad   = 0;

    short_poly_seq #(.P(P), .SEED_DEFAULT(SEED_DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .coef       (coef),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_idx   (coef_idx),
        .weight     (weight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] xs(input logic [31:0] s);
        logic [31:0] t1;
        logic [31:0] t2;
        t1 = s ^ (s >> 7);
        t2 = t1 ^ (t1 << 9);
        return t2 ^ (t2 >> 13);
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  32'(busy),       32'h0);
        chk({tag, "_done"},  32'(done),       32'h0);
        chk({tag, "_valid"}, 32'(coef_valid), 32'h0);
        chk({tag, "_coef"},  32'(coef),       32'h0);
        chk({tag, "_idx"},   32'(coef_idx),   32'h0);
        chk({tag, "_wgt"},   32'(weight),     32'h0);
    endtask

    // One run checked against the model. abort_at/rst_at: fire on the cycle whose
    // presented coefficient has that transfer count (-1 disables).
    task automatic do_run(input string nm, input logic [31:0] sd, input int rdy_pct,
                          input int abort_at, input int rst_at, input bit hold_start,
                          input int exp_x, input int exp_idx);
        logic [31:0] ms;
        logic [12:0] exp_coef;
        int          xfers;
        int          nz;
        int          cyc;
        bit          have_cur;
        bit          fin;
        bit          do_rst;
        bit          will_x;

        ms       = (sd == 32'h0) ? SEED_DEF : sd;
        exp_coef = '0;
        xfers    = 0;
        nz       = 0;
        cyc      = 0;
        have_cur = 1'b0;
        fin      = 1'b0;
        seed       = sd;
        start      = 1'b1;
        coef_ready = 1'b0;
        tick();
        start = hold_start;
        chk({nm, "_lat_valid"}, 32'(coef_valid), 32'h0);
        chk({nm, "_busy"},      32'(busy),       32'h1);

        while (!fin) begin
            if (cyc > 20000) begin
                chk({nm, "_timeout_done"}, 32'(done), 32'h1);
                fin = 1'b1;
            end else if (done) begin
                chk({nm, "_end_valid"}, 32'(coef_valid), 32'h0);
                chk({nm, "_xfers"},     32'(xfers),      32'(exp_x));
                chk({nm, "_end_idx"},   32'(coef_idx),   32'(exp_idx));
                chk({nm, "_weight"},    32'(weight),     32'(nz));
                tick();
                chk({nm, "_done_once"}, 32'(done), 32'h0);
                chk({nm, "_idle_busy"}, 32'(busy), 32'h0);
                chk({nm, "_hold_idx"},  32'(coef_idx), 32'(exp_idx));
                tick();
                chk({nm, "_restart_busy"}, 32'(busy), 32'(hold_start));
                chk({nm, "_post_done"},    32'(done), 32'h0);
                fin = 1'b1;
            end else begin
                if (coef_valid) begin
                    if (!have_cur) begin
                        do ms = xs(ms); while (ms[1:0] == 2'b11);
                        exp_coef = (ms[1:0] == 2'b00) ? 13'h0000 :
                                   (ms[1:0] == 2'b01) ? 13'h0001 : 13'h1FFF;
                        have_cur = 1'b1;
                    end
                    chk({nm, "_coef"}, 32'(coef),     32'(exp_coef));
                    chk({nm, "_idx"},  32'(coef_idx), 32'(xfers));
                end
                coef_ready = ($urandom_range(0, 99) < rdy_pct);
                abort      = 1'b0;
                if (coef_valid && xfers == abort_at) begin
                    coef_ready = 1'b1;
                    abort      = 1'b1;
                end
                do_rst = coef_valid && (rst_at >= 0) && (xfers == rst_at);
                rst    = do_rst;
                will_x = coef_valid && coef_ready && !do_rst;
                tick();
                cyc++;
                abort = 1'b0;
                rst   = 1'b0;
                if (do_rst) begin
                    chk_reset_outputs({nm, "_rst"});
                    for (int i = 0; i < 4; i++) begin
                        tick();
                        chk({nm, "_rst_nodone"}, 32'(done), 32'h0);
                    end
                    fin = 1'b1;
                end else if (will_x) begin
                    xfers++;
                    if (exp_coef != 13'h0) nz++;
                    have_cur = 1'b0;
                end
            end
        end
        start      = 1'b0;
        coef_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        seed       = 32'h0;
        abort      = 1'b1;
        coef_ready = 1'b1;
        tick();
        tick();
        chk_reset_outputs("reset");
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        tick();

        // seed=1: steps give s=0x201 then 0x40825, both map to +1
        seed       = 32'h1;
        start      = 1'b1;
        coef_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("d1_lat_valid", 32'(coef_valid), 32'h0);
        chk("d1_busy",      32'(busy),       32'h1);
        tick();
        chk("d1_valid0", 32'(coef_valid), 32'h1);
        chk("d1_coef0",  32'(coef),       32'h1);
        chk("d1_idx0",   32'(coef_idx),   32'h0);
        tick();
        chk("d1_coef1", 32'(coef),     32'h1);
        chk("d1_idx1",  32'(coef_idx), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("d1_abort_done",  32'(done),       32'h1);
        chk("d1_abort_valid", 32'(coef_valid), 32'h0);
        chk("d1_abort_idx",   32'(coef_idx),   32'h2);
        chk("d1_abort_wgt",   32'(weight),     32'h2);
        tick();
        chk("d1_idle_busy", 32'(busy), 32'h0);
        chk("d1_idle_done", 32'(done), 32'h0);
        coef_ready = 1'b0;
        tick();

        do_run("full_rdy",   32'hDEADBEEF, 100, -1, -1, 1'b0, P, P - 1);
        do_run("full_stall", 32'h12345678, 55,  -1, -1, 1'b0, P, P - 1);
        do_run("seed0",      32'h0,        70,  -1, -1, 1'b0, P, P - 1);
        do_run("seeddef",    SEED_DEF,     40,  -1, -1, 1'b0, P, P - 1);
        // abort rides the transfer that takes coef_idx to 100
        do_run("abort",      32'hCAFEF00D, 80,  99, -1, 1'b0, 100, 100);
        do_run("midrst",     32'h0BADC0DE, 75,  -1, 50, 1'b0, 0, 0);
        do_run("rerun",      32'h0BADC0DE, 75,  -1, -1, 1'b0, P, P - 1);
        do_run("holdstart",  32'h00C0FFEE, 90,  -1, -1, 1'b1, P, P - 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("final_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
